// File: rtl/yrv_mem_arb.sv
// Two-requester round-robin arbiter/sequencer for the single-port MCU memory.
// Optional loader lock (m1_lock port) enabled by defining YRV_ARB_LOCK_EN.
module yrv_mem_arb #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              m0_req,
  input  logic [AW-1:0]     m0_addr,
  input  logic              m0_wr,
  input  logic [DW/8-1:0]   m0_be,
  input  logic [DW-1:0]     m0_wdata,
  input  logic              m1_req,
  input  logic [AW-1:0]     m1_addr,
  input  logic              m1_wr,
  input  logic [DW/8-1:0]   m1_be,
  input  logic [DW-1:0]     m1_wdata,
`ifdef YRV_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic [DW-1:0]     m0_rdata,
  output logic [DW-1:0]     m1_rdata,
  output logic              mem_en,
  output logic [DW/8-1:0]   mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              arb_busy
);

  localparam int unsigned BW = DW / 8;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic        last;
  logic        owner;
  logic [3:0]  wcnt;
  logic        done0_q, done1_q;
  logic        lock;
  logic        eligible, m0_eff, sel0, sel1, issue;

  // State register
  always_ff @(posedge clk) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; WAIT only entered when wait states are configured
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue && (WS != 4'd0)) state_nxt = S_WAIT;
      S_WAIT: if (wcnt == 4'd1)          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: winner selection and combinational memory strobes
  always_comb begin
    eligible  = resetb && (state == S_IDLE);
    m0_eff    = m0_req && !lock;
    sel0      = 1'b0;
    sel1      = 1'b0;
    if (eligible) begin
      // On a tie the requester that did not win last time goes next
      if (m1_req && (!m0_eff || !last)) sel1 = 1'b1;
      else if (m0_eff)                  sel0 = 1'b1;
    end
    issue     = sel0 || sel1;
    m0_gnt    = sel0;
    m1_gnt    = sel1;
    mem_en    = issue;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (sel1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_wr ? m1_be : BW'(0);
    end else if (sel0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_wr ? m0_be : BW'(0);
    end
    arb_busy  = issue || (state == S_WAIT);
    m0_done   = done0_q;
    m1_done   = done1_q;
    m0_rdata  = done0_q ? mem_rdata : DW'(0);
    m1_rdata  = done1_q ? mem_rdata : DW'(0);
  end

  // Arbitration history, wait counter and completion pulses
  always_ff @(posedge clk) begin
    if (!resetb) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      wcnt    <= 4'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (issue) begin
        last  <= sel1;
        owner <= sel1;
        wcnt  <= WS;
      end else if (state == S_WAIT) begin
        wcnt  <= wcnt - 4'd1;
      end
      if (WS == 4'd0) begin
        done0_q <= sel0;
        done1_q <= sel1;
      end else if ((state == S_WAIT) && (wcnt == 4'd1)) begin
        done0_q <= !owner;
        done1_q <= owner;
      end
    end
  end

`ifdef YRV_ARB_LOCK_EN
  // Loader lock: holds off m0 across an m1 burst until released
  always_ff @(posedge clk) begin
    if (!resetb)                lock <= 1'b0;
    else if (sel1)              lock <= m1_lock;
    else if (eligible && !m1_req) lock <= 1'b0;
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_yrv_mem_arb.sv
// Self-checking bench for yrv_mem_arb: one instance with 0 wait states, one with 3.
module tb_yrv_mem_arb;

  logic        clk, resetb;
  logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock;
  logic [15:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata, mem_rdata;

  logic        a_gnt0, a_gnt1, a_done0, a_done1, a_en, a_busy;
  logic [31:0] a_rdata0, a_rdata1, a_wdata;
  logic [3:0]  a_we;
  logic [15:0] a_addr;
  logic        b_gnt0, b_gnt1, b_done0, b_done1, b_en, b_busy;
  logic [31:0] b_rdata0, b_rdata1, b_wdata;
  logic [3:0]  b_we;
  logic [15:0] b_addr;

  typedef struct packed { logic who; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  yrv_mem_arb #(.AW(16), .DW(32), .WAIT_STATES(0)) dut_a (
    .clk(clk), .resetb(resetb),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_be(m1_be), .m1_wdata(m1_wdata),
`ifdef YRV_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m0_gnt(a_gnt0), .m1_gnt(a_gnt1), .m0_done(a_done0), .m1_done(a_done1),
    .m0_rdata(a_rdata0), .m1_rdata(a_rdata1), .mem_en(a_en), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(mem_rdata), .arb_busy(a_busy));

  yrv_mem_arb #(.AW(16), .DW(32), .WAIT_STATES(3)) dut_b (
    .clk(clk), .resetb(resetb),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_be(m1_be), .m1_wdata(m1_wdata),
`ifdef YRV_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m0_gnt(b_gnt0), .m1_gnt(b_gnt1), .m0_done(b_done0), .m1_done(b_done1),
    .m0_rdata(b_rdata0), .m1_rdata(b_rdata1), .mem_en(b_en), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(mem_rdata), .arb_busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    step(); step();
    resetb = 1'b1;
    exp_q.delete();
  endtask

  task automatic pop_exp();
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL sb_underflow got=empty exp=entry"); e = '0;
    end else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    resetb = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b1; m1_wr = 1'b1;
    m0_be = 4'hF; m1_be = 4'hF; m0_addr = 16'h1234; m1_addr = 16'h5678;
    m0_wdata = 32'h1111_1111; m1_wdata = 32'h2222_2222; mem_rdata = 32'h0;
    step(); step();
    #2;
    checks++; if ({a_gnt0, a_gnt1, a_en} !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b exp=000", {a_gnt0, a_gnt1, a_en}); end
    checks++; if (a_we !== 4'h0) begin failures++; $display("FAIL rst_we got=%h exp=0", a_we); end
    checks++; if ({a_done0, a_done1, b_done0, b_done1} !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", {a_done0, a_done1, b_done0, b_done1}); end
    step();
    resetb = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    #2;
    checks++; if ({a_en, a_addr, a_wdata} !== 49'h0) begin failures++; $display("FAIL noreq_mem got=%b/%h/%h exp=0/0/0", a_en, a_addr, a_wdata); end
    checks++; if ({a_busy, b_busy} !== 2'b00) begin failures++; $display("FAIL noreq_busy got=%b exp=00", {a_busy, b_busy}); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0010; m0_be = 4'hF;
    #2;
    checks++; if ({a_gnt0, a_gnt1, a_en} !== 3'b101) begin failures++; $display("FAIL rd_gnt got=%b exp=101", {a_gnt0, a_gnt1, a_en}); end
    checks++; if (a_addr !== 16'h0010 || a_we !== 4'h0) begin failures++; $display("FAIL rd_mem got=%h/%h exp=0010/0", a_addr, a_we); end
    exp_q.push_back('{who: 1'b0, data: 32'hDEAD_BEEF});
    step();
    m0_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #2;
    pop_exp();
    checks++; if ({a_done1, a_done0} !== 2'b01) begin failures++; $display("FAIL rd_done got=%b exp=01", {a_done1, a_done0}); end
    checks++; if (a_rdata0 !== e.data || a_rdata1 !== 32'h0) begin failures++; $display("FAIL rd_data got=%h/%h exp=%h/0", a_rdata0, a_rdata1, e.data); end
    step();
  endtask

  task automatic test_write();
    do_reset();
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0200; m1_be = 4'b0011; m1_wdata = 32'h1234_5678;
    #2;
    checks++; if ({a_gnt0, a_gnt1, a_en} !== 3'b011) begin failures++; $display("FAIL wr_gnt got=%b exp=011", {a_gnt0, a_gnt1, a_en}); end
    checks++; if (a_we !== 4'b0011 || a_addr !== 16'h0200 || a_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_mem got=%h/%h/%h exp=3/0200/12345678", a_we, a_addr, a_wdata); end
    exp_q.push_back('{who: 1'b1, data: 32'h0BAD_F00D});
    step();
    m1_req = 1'b0; mem_rdata = 32'h0BAD_F00D;
    #2;
    pop_exp();
    checks++; if ({a_done1, a_done0} !== 2'b10 || a_rdata1 !== e.data) begin failures++; $display("FAIL wr_done got=%b/%h exp=10/%h", {a_done1, a_done0}, a_rdata1, e.data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic w;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_rdata = 32'hA000_0000 + 32'(c);
      #2;
      w = (c % 2) == 1;
      checks++; if ({a_gnt1, a_gnt0} !== {w, !w}) begin failures++; $display("FAIL b2b_gnt%0d got=%b exp=%b", c, {a_gnt1, a_gnt0}, {w, !w}); end
      if (c > 0) begin
        pop_exp();
        checks++; if ({a_done1, a_done0} !== {e.who, !e.who} || (e.who ? a_rdata1 : a_rdata0) !== e.data) begin failures++; $display("FAIL b2b_done%0d got=%b/%h exp=%b/%h", c, {a_done1, a_done0}, e.who ? a_rdata1 : a_rdata0, {e.who, !e.who}, e.data); end
      end
      exp_q.push_back('{who: w, data: 32'hA000_0000 + 32'(c + 1)});
      step();
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_rdata = 32'hA000_0006;
    #2;
    pop_exp();
    checks++; if ({a_done1, a_done0} !== {e.who, !e.who} || a_rdata1 !== e.data) begin failures++; $display("FAIL b2b_last got=%b/%h exp=%b/%h", {a_done1, a_done0}, a_rdata1, {e.who, !e.who}, e.data); end
    step();
  endtask

  task automatic test_wait_states();
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0040;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h0080; m1_be = 4'hF; m1_wdata = 32'h55AA_55AA;
    mem_rdata = 32'h0;
    #2;
    checks++; if ({b_gnt1, b_gnt0, b_busy} !== 3'b011) begin failures++; $display("FAIL ws_issue got=%b exp=011", {b_gnt1, b_gnt0, b_busy}); end
    exp_q.push_back('{who: 1'b0, data: 32'hCAFE_0004});
    step();
    m0_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      m1_addr = 16'h0080 + 16'(k * 4);
      #2;
      checks++; if ({b_busy, b_gnt1, b_gnt0, b_en, b_done1, b_done0} !== 6'b100000) begin failures++; $display("FAIL ws_wait%0d got=%b exp=100000", k, {b_busy, b_gnt1, b_gnt0, b_en, b_done1, b_done0}); end
      step();
    end
    mem_rdata = 32'hCAFE_0004;
    #2;
    pop_exp();
    checks++; if ({b_done1, b_done0} !== 2'b01 || b_rdata0 !== e.data) begin failures++; $display("FAIL ws_done0 got=%b/%h exp=01/%h", {b_done1, b_done0}, b_rdata0, e.data); end
    checks++; if ({b_gnt1, b_busy} !== 2'b11 || b_addr !== 16'h008C || b_we !== 4'hF) begin failures++; $display("FAIL ws_gnt1 got=%b/%h/%h exp=11/008c/f", {b_gnt1, b_busy}, b_addr, b_we); end
    exp_q.push_back('{who: 1'b1, data: 32'hCAFE_0008});
    step();
    m1_req = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      #2;
      checks++; if ({b_busy, b_done1, b_done0} !== 3'b100) begin failures++; $display("FAIL ws_wait%0d got=%b exp=100", k, {b_busy, b_done1, b_done0}); end
      step();
    end
    mem_rdata = 32'hCAFE_0008;
    #2;
    pop_exp();
    checks++; if ({b_done1, b_done0, b_busy} !== 3'b100 || b_rdata1 !== e.data) begin failures++; $display("FAIL ws_done1 got=%b/%h exp=100/%h", {b_done1, b_done0, b_busy}, b_rdata1, e.data); end
    step();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0044;
    #2;
    checks++; if (b_gnt0 !== 1'b1) begin failures++; $display("FAIL rma_issue got=%b exp=1", b_gnt0); end
    step();
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b1; resetb = 1'b0;
    #2;
    checks++; if ({b_gnt1, b_en, b_we} !== 6'b0) begin failures++; $display("FAIL rma_forced got=%b exp=0", {b_gnt1, b_en, b_we}); end
    step();
    resetb = 1'b1; m1_req = 1'b0;
    #2;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rma_idle got=%b exp=0", b_busy); end
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++; if ({b_done1, b_done0} !== 2'b00) begin failures++; $display("FAIL rma_nodone%0d got=%b exp=00", k, {b_done1, b_done0}); end
      step();
    end
    m0_req = 1'b1; m1_req = 1'b1;
    #2;
    checks++; if ({b_gnt1, b_gnt0} !== 2'b01) begin failures++; $display("FAIL rma_tie got=%b exp=01", {b_gnt1, b_gnt0}); end
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
  endtask

`ifdef YRV_ARB_LOCK_EN
  task automatic test_lock();
    logic [2:0] lk;
    do_reset();
    lk = 3'b011;
    m0_req = 1'b1; m0_wr = 1'b0;
    #2;
    checks++; if (a_gnt0 !== 1'b1) begin failures++; $display("FAIL lock_pre got=%b exp=1", a_gnt0); end
    step();
    m1_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m1_lock = lk[k];
      #2;
      checks++; if ({a_gnt1, a_gnt0} !== 2'b10) begin failures++; $display("FAIL lock_m1_%0d got=%b exp=10", k, {a_gnt1, a_gnt0}); end
      step();
    end
    m1_req = 1'b0; m1_lock = 1'b0;
    #2;
    checks++; if ({a_gnt1, a_gnt0} !== 2'b01) begin failures++; $display("FAIL lock_m0 got=%b exp=01", {a_gnt1, a_gnt0}); end
    step();
    m0_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_access();
`ifdef YRV_ARB_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
